router_addr_gen: RTL and testbench
==================================

Name: router_addr_gen

Overview:
Per-row address generator directly downstream of the router controller. It captures output-feature-map coordinates tagged with its row id and expands each one into the k*k input-feature-map addresses of the kernel window. Addresses are buffered in a show-ahead FIFO that the tile reader/address comparator pops. The FIFO empty flag is the i_addr_empty status returned to the controller.

Parameters:
ROW_ID, 0, row index this instance answers to
ROW_COUNT, 4, width of i_row_id
ADDR_WIDTH, 8, coordinate/address width
K_MAX, 7, largest supported kernel side
FIFO_DEPTH, 16, address FIFO entries; power of two, >= 2

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; one clock; reset is asynchronous and active-high
i_reg_clear  in  1  synchronous clear of all state
i_en  in  1  coordinate strobe (controller ag_en)
i_row_id  in  ROW_COUNT  row tag of the current coordinate
i_o_x, i_o_y  in  ADDR_WIDTH  output coordinate (already stride-scaled)
i_start_addr  in  ADDR_WIDTH  base address of input map
i_i_size  in  ADDR_WIDTH  input map row pitch
i_k_size  in  $clog2(K_MAX+1)  kernel side, 1..K_MAX
i_pop  in  1  pop FIFO head
o_addr  out  ADDR_WIDTH  FIFO head (valid when !o_addr_empty)
o_addr_empty  out  1  FIFO empty
o_busy  out  1  window generation in progress or pending coordinate held
o_win_done  out  1  one-cycle pulse when last address of a window is pushed
o_overflow  out  1  sticky: coordinate dropped

Behaviour:
- Reset/clear: i_rst (async) or i_reg_clear (sync, highest priority over all other inputs) empties FIFO, drops pending, returns to IDLE, clears counters and o_overflow. Outputs: o_addr=0, o_addr_empty=1, o_busy=0, o_win_done=0, o_overflow=0. Mid-window reset/clear abandons the window with no further pushes.
- Capture: coordinate accepted on a cycle with i_en=1 and i_row_id==ROW_ID. Other row ids are ignored.
- FSM IDLE: on capture, latch x,y and go to GEN with kx=ky=0.
- FSM GEN: each cycle the FIFO is not full, push start + (y+ky)*i_i_size + (x+kx), then advance kx. kx is the inner loop and wraps at i_k_size-1, incrementing ky. The push of kx=ky=k-1 pulses o_win_done. It then loads the pending coordinate and stays in GEN if one is held, else returns to IDLE. When the FIFO is full, hold with no push and counters frozen.
- i_k_size, i_start_addr and i_i_size are sampled at capture and held for the whole window.
- Pending: a capture while in GEN fills a one-entry pending register. A capture with pending already full is dropped and sets o_overflow. A capture in the same cycle as the window-last push loads directly as the next window.
- o_busy = (state==GEN) | pending_valid.
- Arithmetic: the sum is computed at 2*ADDR_WIDTH and truncated to ADDR_WIDTH (modulo wrap). There is no range check.
- Latency: capture at cycle N, first push at end of N+1, o_addr_empty low from N+2. Without backpressure, one address per cycle and k*k cycles per window.
- FIFO: show-ahead. i_pop while empty is ignored. Push is allowed only when count<FIFO_DEPTH; a same-cycle pop does not free a slot for that cycle's push. Simultaneous push and pop with 0<count<FIFO_DEPTH leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- router_pkg: gen_state_t enum (IDLE, GEN) and the ADDR_WIDTH default.
- Sub-module addr_fifo (parameterised sync show-ahead FIFO with count, full and empty flags) instantiated once. The FSM, counters and pending register live in router_addr_gen.

Test Plan:
- ROW_ID=0, k=3, i_size=8, start=0x10, x=2, y=1 -> 0x1A,0x1B,0x1C,0x22,0x23,0x24,0x2A,0x2B,0x2C in order; o_win_done on 9th push; o_addr_empty low at N+2.
- Strobe with i_row_id=2 on a ROW_ID=0 instance -> no push; o_busy stays 0.
- FIFO_DEPTH=4, k=3, no pops for 10 cycles -> exactly 4 entries, counters hold; then pop every cycle -> all 9 addresses delivered in order with no loss or duplicates.
- Second capture (x=0,y=0, k=3) during window 1 -> held pending; 0x10,0x11,0x12,0x18... follow immediately after window 1; third capture while pending full -> o_overflow=1 and stays set.
- i_reg_clear after 4 pushes in GEN -> next cycle o_addr_empty=1, o_busy=0, o_overflow=0, no further pushes; i_rst asserted mid-window gives the same result asynchronously.
- ADDR_WIDTH=8, start=0xF0, i_size=16, y=1, x=0, k=1 -> single address 0x00 (wrap).

Source files
------------

// File: rtl/router_pkg.sv
// Shared types for the router address generator slice.
package router_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE,
        GEN
    } gen_state_t;

endpackage

// File: rtl/addr_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and full/empty flags.
module addr_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    // Full is judged before any same-cycle pop, so a pop never makes room for a push.
    assign do_push = i_push && !o_full && !i_clear;
    assign do_pop  = i_pop && !o_empty && !i_clear;
    assign o_data  = o_empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/router_addr_gen.sv
// Per-row kernel-window address generator: expands captured output coordinates into
// k*k input-map addresses and queues them in a show-ahead FIFO.
module router_addr_gen
    import router_pkg::*;
#(
    parameter int unsigned ROW_ID     = 0,
    parameter int unsigned ROW_COUNT  = 4,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned K_MAX      = 7,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned KW = $clog2(K_MAX + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_reg_clear,
    input  logic                  i_en,
    input  logic [ROW_COUNT-1:0]  i_row_id,
    input  logic [ADDR_WIDTH-1:0] i_o_x,
    input  logic [ADDR_WIDTH-1:0] i_o_y,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [KW-1:0]         i_k_size,
    input  logic                  i_pop,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_addr_empty,
    output logic                  o_busy,
    output logic                  o_win_done,
    output logic                  o_overflow
);

    localparam int unsigned CRD_W = 4 * ADDR_WIDTH + KW;
    localparam int unsigned W2    = 2 * ADDR_WIDTH;

    gen_state_t       state_q, state_d;
    logic [CRD_W-1:0] cur_q, cur_d, pend_q, pend_d, in_crd;
    logic             pend_valid_q, pend_valid_d;
    logic [KW-1:0]    kx_q, kx_d, ky_q, ky_d;
    logic             overflow_q, overflow_d;

    logic [ADDR_WIDTH-1:0] cur_x, cur_y, cur_start, cur_isize;
    logic [KW-1:0]         cur_k;
    logic [W2-1:0]         sum;
    logic                  capture, push, fifo_full, kx_last, ky_last, win_last;
    logic                  unused_sum_hi;
    logic [$clog2(FIFO_DEPTH+1)-1:0] unused_fifo_count;

    // Window parameters travel with the coordinate so they stay fixed for its whole window.
    assign in_crd = {i_o_x, i_o_y, i_start_addr, i_i_size, i_k_size};
    assign {cur_x, cur_y, cur_start, cur_isize, cur_k} = cur_q;

    assign capture  = i_en && (i_row_id == ROW_COUNT'(ROW_ID));
    assign push     = (state_q == GEN) && !fifo_full && !i_reg_clear;
    assign kx_last  = (kx_q == cur_k - KW'(1));
    assign ky_last  = (ky_q == cur_k - KW'(1));
    assign win_last = push && kx_last && ky_last;

    assign sum = W2'(cur_start) + (W2'(cur_y) + W2'(ky_q)) * W2'(cur_isize)
               + W2'(cur_x) + W2'(kx_q);
    assign unused_sum_hi = ^sum[W2-1:ADDR_WIDTH];

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        kx_d         = kx_q;
        ky_d         = ky_q;
        overflow_d   = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    cur_d   = in_crd;
                    kx_d    = '0;
                    ky_d    = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (push) begin
                    if (kx_last) begin
                        kx_d = '0;
                        ky_d = ky_q + KW'(1);
                    end else begin
                        kx_d = kx_q + KW'(1);
                    end
                end
                if (win_last) begin
                    kx_d = '0;
                    ky_d = '0;
                    if (pend_valid_q) begin
                        cur_d        = pend_q;
                        pend_valid_d = capture;
                        if (capture) pend_d = in_crd;
                    end else if (capture) begin
                        cur_d = in_crd;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (capture) begin
                    if (pend_valid_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        pend_d       = in_crd;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_reg_clear) begin
            state_d      = IDLE;
            cur_d        = '0;
            pend_d       = '0;
            pend_valid_d = 1'b0;
            kx_d         = '0;
            ky_d         = '0;
            overflow_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            kx_q         <= '0;
            ky_q         <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            kx_q         <= kx_d;
            ky_q         <= ky_d;
            overflow_q   <= overflow_d;
        end
    end

    addr_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_addr_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_reg_clear),
        .i_push  (push),
        .i_data  (sum[ADDR_WIDTH-1:0]),
        .i_pop   (i_pop),
        .o_data  (o_addr),
        .o_count (unused_fifo_count),
        .o_full  (fifo_full),
        .o_empty (o_addr_empty)
    );

    assign o_busy     = (state_q == GEN) || pend_valid_q;
    assign o_win_done = win_last;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_router_addr_gen.sv
// Directed self-checking bench for router_addr_gen (16-deep and 4-deep instances).
module tb_router_addr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reg_clear = 1'b0;
    logic       en = 1'b0;
    logic [3:0] row_id = '0;
    logic [7:0] o_x = '0, o_y = '0, start = '0, isize = '0;
    logic [2:0] k_size = '0;
    logic       pop = 1'b0, pop4 = 1'b0;

    logic [7:0] addr, addr4;
    logic       addr_empty, busy, win_done, overflow;
    logic       addr_empty4, busy4, win_done4, overflow4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    router_addr_gen #(
        .ROW_ID(0), .ROW_COUNT(4), .ADDR_WIDTH(8), .K_MAX(7), .FIFO_DEPTH(16)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_reg_clear(reg_clear), .i_en(en), .i_row_id(row_id),
        .i_o_x(o_x), .i_o_y(o_y), .i_start_addr(start), .i_i_size(isize),
        .i_k_size(k_size), .i_pop(pop), .o_addr(addr), .o_addr_empty(addr_empty),
        .o_busy(busy), .o_win_done(win_done), .o_overflow(overflow)
    );

    router_addr_gen #(
        .ROW_ID(0), .ROW_COUNT(4), .ADDR_WIDTH(8), .K_MAX(7), .FIFO_DEPTH(4)
    ) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_reg_clear(reg_clear), .i_en(en), .i_row_id(row_id),
        .i_o_x(o_x), .i_o_y(o_y), .i_start_addr(start), .i_i_size(isize),
        .i_k_size(k_size), .i_pop(pop4), .o_addr(addr4), .o_addr_empty(addr_empty4),
        .o_busy(busy4), .o_win_done(win_done4), .o_overflow(overflow4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; pop = 1'b0; pop4 = 1'b0; reg_clear = 1'b0; row_id = '0;
    endtask

    task automatic set_coord(input logic [7:0] x, input logic [7:0] y, input logic [2:0] k,
                             input logic [7:0] st, input logic [7:0] sz);
        en = 1'b1; row_id = '0; o_x = x; o_y = y; k_size = k; start = st; isize = sz;
    endtask

    task automatic do_reset();
        cyc();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        n_cmp++;
        if ({addr, addr_empty, busy, win_done, overflow} !== {8'h00, 4'b1000})
            $display("FAIL reset_outputs: got addr=%h e=%b b=%b w=%b o=%b want 00 1 0 0 0",
                     addr, addr_empty, busy, win_done, overflow);
        n_cmp++;
        if ({addr4, addr_empty4, busy4, overflow4} !== {8'h00, 3'b100})
            $display("FAIL reset_outputs4: got addr=%h e=%b b=%b o=%b want 00 1 0 0",
                     addr4, addr_empty4, busy4, overflow4);
        if ({addr, addr_empty, busy, win_done, overflow} !== {8'h00, 4'b1000} ||
            {addr4, addr_empty4, busy4, overflow4} !== {8'h00, 3'b100}) n_err++;
        rst = 1'b0;
    endtask

    task automatic test_window();
        logic [7:0] exp [9];
        exp = '{8'h1A, 8'h1B, 8'h1C, 8'h22, 8'h23, 8'h24, 8'h2A, 8'h2B, 8'h2C};
        do_reset();
        cyc(); set_coord(8'd2, 8'd1, 3'd3, 8'h10, 8'd8); settle();
        n_cmp++;
        if (addr_empty !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL win_capture_cycle: got e=%b b=%b want e=1 b=0", addr_empty, busy);
        end
        for (int i = 0; i < 9; i++) begin
            cyc(); en = 1'b0; settle();
            n_cmp++;
            if (win_done !== (i == 8)) begin
                n_err++; $display("FAIL win_done[%0d]: got %b want %b", i, win_done, (i == 8));
            end
            if (i == 0) begin
                n_cmp++;
                if (addr_empty !== 1'b1 || busy !== 1'b1) begin
                    n_err++; $display("FAIL win_n1: got e=%b b=%b want e=1 b=1", addr_empty, busy);
                end
            end
            if (i == 1) begin
                n_cmp++;
                if (addr_empty !== 1'b0 || addr !== 8'h1A) begin
                    n_err++; $display("FAIL win_n2: got e=%b addr=%h want e=0 addr=1a", addr_empty, addr);
                end
            end
        end
        cyc(); settle();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL win_idle_after: got busy=%b want 0", busy);
        end
        for (int i = 0; i < 9; i++) begin
            pop = 1'b1;
            n_cmp++;
            if (addr_empty !== 1'b0 || addr !== exp[i]) begin
                n_err++; $display("FAIL win_addr[%0d]: got e=%b addr=%h want e=0 addr=%h",
                                  i, addr_empty, addr, exp[i]);
            end
            cyc(); settle();
        end
        pop = 1'b0;
        n_cmp++;
        if (addr_empty !== 1'b1) begin
            n_err++; $display("FAIL win_drained: got e=%b want 1", addr_empty);
        end
    endtask

    task automatic test_other_row();
        do_reset();
        for (int r = 1; r < 4; r++) begin
            cyc(); set_coord(8'd2, 8'd1, 3'd3, 8'h10, 8'd8); row_id = 4'(r); settle();
            cyc(); en = 1'b0; settle();
            n_cmp++;
            if (busy !== 1'b0 || addr_empty !== 1'b1) begin
                n_err++; $display("FAIL other_row[%0d]: got b=%b e=%b want b=0 e=1", r, busy, addr_empty);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [9];
        exp = '{8'h1A, 8'h1B, 8'h1C, 8'h22, 8'h23, 8'h24, 8'h2A, 8'h2B, 8'h2C};
        do_reset();
        cyc(); set_coord(8'd2, 8'd1, 3'd3, 8'h10, 8'd8); settle();
        cyc(); en = 1'b0;
        repeat (9) cyc();
        settle();
        n_cmp++;
        if (busy4 !== 1'b1 || addr_empty4 !== 1'b0 || addr4 !== 8'h1A || win_done4 !== 1'b0) begin
            n_err++; $display("FAIL bp_hold: got b=%b e=%b addr=%h w=%b want 1 0 1a 0",
                              busy4, addr_empty4, addr4, win_done4);
        end
        for (int i = 0; i < 9; i++) begin
            pop4 = 1'b1;
            n_cmp++;
            if (addr_empty4 !== 1'b0 || addr4 !== exp[i]) begin
                n_err++; $display("FAIL bp_addr[%0d]: got e=%b addr=%h want e=0 addr=%h",
                                  i, addr_empty4, addr4, exp[i]);
            end
            cyc(); settle();
        end
        pop4 = 1'b0;
        n_cmp++;
        if (addr_empty4 !== 1'b1 || busy4 !== 1'b0) begin
            n_err++; $display("FAIL bp_drained: got e=%b b=%b want e=1 b=0", addr_empty4, busy4);
        end
    endtask

    task automatic test_pending();
        logic [7:0] exp [18];
        exp = '{8'h1A, 8'h1B, 8'h1C, 8'h22, 8'h23, 8'h24, 8'h2A, 8'h2B, 8'h2C,
                8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A, 8'h20, 8'h21, 8'h22};
        do_reset();
        cyc(); set_coord(8'd2, 8'd1, 3'd3, 8'h10, 8'd8); settle();
        cyc(); set_coord(8'd0, 8'd0, 3'd3, 8'h10, 8'd8); settle();
        for (int i = 0; i < 18; i++) begin
            cyc();
            if (i == 0) set_coord(8'd5, 8'd5, 3'd2, 8'h00, 8'd8);
            else en = 1'b0;
            pop = 1'b1;
            settle();
            n_cmp++;
            if (addr_empty !== 1'b0 || addr !== exp[i]) begin
                n_err++; $display("FAIL pend_addr[%0d]: got e=%b addr=%h want e=0 addr=%h",
                                  i, addr_empty, addr, exp[i]);
            end
            if (i == 1) begin
                n_cmp++;
                if (overflow !== 1'b1) begin
                    n_err++; $display("FAIL pend_overflow_set: got %b want 1", overflow);
                end
            end
        end
        cyc(); pop = 1'b0; settle();
        n_cmp++;
        if (addr_empty !== 1'b1 || busy !== 1'b0 || overflow !== 1'b1) begin
            n_err++; $display("FAIL pend_end: got e=%b b=%b o=%b want e=1 b=0 o=1",
                              addr_empty, busy, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [5];
        exp = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h08};
        do_reset();
        cyc(); set_coord(8'd0, 8'd0, 3'd2, 8'h00, 8'd4); settle();
        cyc(); en = 1'b0; settle();
        for (int i = 0; i < 5; i++) begin
            cyc();
            en = 1'b0;
            if (i == 2) set_coord(8'd8, 8'd0, 3'd1, 8'h00, 8'd4);
            pop = 1'b1;
            settle();
            n_cmp++;
            if (addr_empty !== 1'b0 || addr !== exp[i]) begin
                n_err++; $display("FAIL b2b_addr[%0d]: got e=%b addr=%h want e=0 addr=%h",
                                  i, addr_empty, addr, exp[i]);
            end
            if (i == 2 || i == 3) begin
                n_cmp++;
                if (win_done !== 1'b1) begin
                    n_err++; $display("FAIL b2b_win_done[%0d]: got %b want 1", i, win_done);
                end
            end
        end
        cyc(); pop = 1'b0; settle();
        n_cmp++;
        if (addr_empty !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL b2b_end: got e=%b b=%b o=%b want e=1 b=0 o=0",
                              addr_empty, busy, overflow);
        end
    endtask

    task automatic test_clear();
        // Synchronous clear four pushes into a window, with a pending entry and overflow set.
        do_reset();
        cyc(); set_coord(8'd2, 8'd1, 3'd3, 8'h10, 8'd8);
        cyc(); set_coord(8'd0, 8'd0, 3'd3, 8'h10, 8'd8);
        cyc();
        cyc(); en = 1'b0;
        cyc();
        cyc(); set_coord(8'd1, 8'd1, 3'd3, 8'h10, 8'd8); reg_clear = 1'b1; pop = 1'b1; settle();
        n_cmp++;
        if (win_done !== 1'b0 || overflow !== 1'b1) begin
            n_err++; $display("FAIL clr_cycle: got w=%b o=%b want w=0 o=1", win_done, overflow);
        end
        cyc(); idle_inputs(); settle();
        n_cmp++;
        if ({addr, addr_empty, busy, overflow} !== {8'h00, 3'b100}) begin
            n_err++; $display("FAIL clr_after: got addr=%h e=%b b=%b o=%b want 00 1 0 0",
                              addr, addr_empty, busy, overflow);
        end
        repeat (3) cyc();
        settle();
        n_cmp++;
        if (addr_empty !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL clr_no_push: got e=%b b=%b want e=1 b=0", addr_empty, busy);
        end
        // Asynchronous reset at the same point in a window.
        cyc(); set_coord(8'd2, 8'd1, 3'd3, 8'h10, 8'd8);
        cyc(); set_coord(8'd0, 8'd0, 3'd3, 8'h10, 8'd8);
        cyc();
        cyc(); en = 1'b0;
        cyc();
        cyc(); settle();
        rst = 1'b1; settle();
        n_cmp++;
        if ({addr, addr_empty, busy, win_done, overflow} !== {8'h00, 4'b1000}) begin
            n_err++; $display("FAIL rst_async: got addr=%h e=%b b=%b w=%b o=%b want 00 1 0 0 0",
                              addr, addr_empty, busy, win_done, overflow);
        end
        cyc(); rst = 1'b0;
        repeat (3) cyc();
        settle();
        n_cmp++;
        if (addr_empty !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL rst_no_push: got e=%b b=%b o=%b want e=1 b=0 o=0",
                              addr_empty, busy, overflow);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(); pop = 1'b1; settle();
        cyc(); pop = 1'b0; set_coord(8'd0, 8'd1, 3'd1, 8'hF0, 8'd16); settle();
        n_cmp++;
        if (addr_empty !== 1'b1) begin
            n_err++; $display("FAIL wrap_pop_empty: got e=%b want 1", addr_empty);
        end
        cyc(); en = 1'b0; settle();
        n_cmp++;
        if (win_done !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL wrap_done: got w=%b b=%b want w=1 b=1", win_done, busy);
        end
        cyc(); settle();
        n_cmp++;
        if (addr_empty !== 1'b0 || addr !== 8'h00 || busy !== 1'b0) begin
            n_err++; $display("FAIL wrap_addr: got e=%b addr=%h b=%b want e=0 addr=00 b=0",
                              addr_empty, addr, busy);
        end
        pop = 1'b1;
        cyc(); pop = 1'b0; settle();
        n_cmp++;
        if (addr_empty !== 1'b1) begin
            n_err++; $display("FAIL wrap_drained: got e=%b want 1", addr_empty);
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_other_row();
        test_backpressure();
        test_pending();
        test_back_to_back();
        test_clear();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
